gray_gen: RTL and testbench



---
 rtl/gray_gen_pkg.sv | 23 ++
 rtl/gray_gen.sv | 109 ++++++++++
 tb/tb_gray_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gray_gen_pkg.sv
// rtl/gray_gen_pkg.sv - shared types and helpers for the Gray-code sequence generator
package gray_gen_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gray_gen_state_t;

    // Callers zero-extend into GRAY_MAX_W and truncate the result back to their width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] terminal(input logic dir, input int width);
        logic [GRAY_MAX_W-1:0] ones;
        ones = '1;
        return dir ? (ones >> (GRAY_MAX_W - width)) : '0;
    endfunction

endpackage

// File: rtl/gray_gen.sv
// rtl/gray_gen.sv - registered Gray-code generator on a valid/ready stream
// Optional one-shot stop at terminal count: GRAY_GEN_ONESHOT_EN.
module gray_gen #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] START = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] g_out,
    output logic             g_valid,
    input  logic             g_ready,
    output logic             wrap
);
    import gray_gen_pkg::*;

    localparam logic [WIDTH-1:0] START_G = WIDTH'(bin2gray(GRAY_MAX_W'(START)));

    gray_gen_state_t  state_q;
    gray_gen_state_t  state_d;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] bin_step;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] g_d;
    logic             g_valid_d;
    logic             wrap_d;
    logic             xfer;
    logic             load_acc;
    logic             at_term;
    logic             stop_here;

    assign xfer     = g_valid & g_ready;
    // A load only lands when nothing is on offer or the offered code leaves this cycle.
    assign load_acc = load & (~g_valid | xfer);
    assign term_val = WIDTH'(terminal(dir, WIDTH));
    assign at_term  = (bin_q == term_val);
    assign bin_step = dir ? (bin_q + 1'b1) : (bin_q - 1'b1);

`ifdef GRAY_GEN_ONESHOT_EN
    assign stop_here = at_term;
`else
    assign stop_here = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= START;
            g_out   <= START_G;
            g_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            g_out   <= g_d;
            g_valid <= g_valid_d;
            wrap    <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (!en) begin
                        state_d = IDLE;
                    end
`ifdef GRAY_GEN_ONESHOT_EN
                    if (at_term && !load_acc) begin
                        state_d = DONE;
                    end
`endif
                end
            end
`ifdef GRAY_GEN_ONESHOT_EN
            DONE: begin
                if (load_acc) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; g_out follows bin_d so it only moves on advance or load.
    always_comb begin
        bin_d = bin_q;
        if (load_acc) begin
            bin_d = load_val;
        end else if (xfer && !stop_here) begin
            bin_d = bin_step;
        end
        wrap_d    = xfer & at_term & ~load_acc;
        g_d       = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
        g_valid_d = (state_d == RUN);
    end

endmodule

// File: tb/tb_gray_gen.sv
// tb/tb_gray_gen.sv - directed self-checking bench for gray_gen
module tb_gray_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] g_out;
    logic       g_valid;
    logic       g_ready;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_gen #(.WIDTH(4), .START(4'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .g_out    (g_out),
        .g_valid  (g_valid),
        .g_ready  (g_ready),
        .wrap     (wrap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = 4'h0; g_ready = 1'b0;
        step(); step();
        checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", g_valid); end
        checks++; if (g_out !== 4'h0) begin errors++; $display("FAIL reset_g_out: got %h expected 0", g_out); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        rst_n = 1'b1;
        step();
        checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", g_valid); end
        checks++; if (g_out !== 4'h0) begin errors++; $display("FAIL idle_g_out: got %h expected 0", g_out); end
    endtask

    task automatic test_stream_up();
        logic [3:0] exp_g [17];
        exp_g = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                  4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        en = 1'b1; dir = 1'b1; g_ready = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            checks++; if (g_out !== exp_g[i]) begin errors++; $display("FAIL up_g_out[%0d]: got %h expected %h", i, g_out, exp_g[i]); end
            checks++; if (g_valid !== 1'b1) begin errors++; $display("FAIL up_valid[%0d]: got %b expected 1", i, g_valid); end
            checks++; if (wrap !== (i == 16)) begin errors++; $display("FAIL up_wrap[%0d]: got %b expected %b", i, wrap, (i == 16)); end
            step();
        end
    endtask

    task automatic test_backpressure();
        checks++; if (g_out !== 4'h1) begin errors++; $display("FAIL bp_pre_g_out: got %h expected 1", g_out); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL bp_pre_wrap: got %b expected 0", wrap); end
        step();
        checks++; if (g_out !== 4'h3) begin errors++; $display("FAIL bp_show3: got %h expected 3", g_out); end
        for (int k = 0; k < 3; k++) begin
            g_ready = 1'b0; dir = k[0]; load = 1'b1; load_val = 4'hC;
            step();
            checks++; if (g_out !== 4'h3) begin errors++; $display("FAIL bp_hold_g_out[%0d]: got %h expected 3", k, g_out); end
            checks++; if (g_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, g_valid); end
        end
        g_ready = 1'b1; load = 1'b0; dir = 1'b1;
        step();
        checks++; if (g_out !== 4'h2) begin errors++; $display("FAIL bp_release: got %h expected 2", g_out); end
        en = 1'b0;
        step();
        checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL bp_stop_valid: got %b expected 0", g_valid); end
        checks++; if (g_out !== 4'h6) begin errors++; $display("FAIL bp_stop_g_out: got %h expected 6", g_out); end
        step();
        checks++; if (g_out !== 4'h6) begin errors++; $display("FAIL bp_idle_hold: got %h expected 6", g_out); end
    endtask

    task automatic test_load_down();
        logic [3:0] exp_g [7];
        exp_g = '{4'h7, 4'h6, 4'h2, 4'h3, 4'h1, 4'h0, 4'h8};
        load = 1'b1; load_val = 4'h5; dir = 1'b0; en = 1'b0;
        step();
        checks++; if (g_out !== 4'h7) begin errors++; $display("FAIL ld_idle_g_out: got %h expected 7", g_out); end
        checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL ld_idle_valid: got %b expected 0", g_valid); end
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++; if (g_out !== exp_g[i]) begin errors++; $display("FAIL dn_g_out[%0d]: got %h expected %h", i, g_out, exp_g[i]); end
            checks++; if (g_valid !== 1'b1) begin errors++; $display("FAIL dn_valid[%0d]: got %b expected 1", i, g_valid); end
            checks++; if (wrap !== (i == 6)) begin errors++; $display("FAIL dn_wrap[%0d]: got %b expected %b", i, wrap, (i == 6)); end
        end
    endtask

    task automatic test_load_xfer();
        en = 1'b0;
        step();
        checks++; if (g_out !== 4'h9) begin errors++; $display("FAIL lx_idle_g_out: got %h expected 9", g_out); end
        checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL lx_idle_valid: got %b expected 0", g_valid); end
        load = 1'b1; load_val = 4'h2; en = 1'b1;
        step();
        checks++; if (g_out !== 4'h3) begin errors++; $display("FAIL lx_load_en_g_out: got %h expected 3", g_out); end
        checks++; if (g_valid !== 1'b1) begin errors++; $display("FAIL lx_load_en_valid: got %b expected 1", g_valid); end
        load = 1'b0;
        step();
        checks++; if (g_out !== 4'h1) begin errors++; $display("FAIL lx_show1: got %h expected 1", g_out); end
        load = 1'b1; load_val = 4'hC;
        step();
        checks++; if (g_out !== 4'hA) begin errors++; $display("FAIL lx_load_xfer: got %h expected A", g_out); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL lx_load_xfer_wrap: got %b expected 0", wrap); end
        load = 1'b0;
        step();
        checks++; if (g_out !== 4'hE) begin errors++; $display("FAIL lx_after_load: got %h expected E", g_out); end
        load = 1'b1; load_val = 4'h0;
        step();
        checks++; if (g_out !== 4'h0) begin errors++; $display("FAIL lx_load0: got %h expected 0", g_out); end
        load = 1'b0;
        step();
        checks++; if (g_out !== 4'h8) begin errors++; $display("FAIL lx_dn_wrap_g_out: got %h expected 8", g_out); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL lx_dn_wrap: got %b expected 1", wrap); end
        dir = 1'b1; load = 1'b1; load_val = 4'h3;
        step();
        checks++; if (g_out !== 4'h2) begin errors++; $display("FAIL lx_term_load_g_out: got %h expected 2", g_out); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL lx_term_load_wrap: got %b expected 0", wrap); end
        load = 1'b0;
        step();
        checks++; if (g_out !== 4'h6) begin errors++; $display("FAIL lx_resume: got %h expected 6", g_out); end
    endtask

    task automatic test_oneshot();
        load = 1'b1; load_val = 4'hE; en = 1'b1; dir = 1'b1; g_ready = 1'b1;
        step();
        checks++; if (g_out !== 4'h9) begin errors++; $display("FAIL os_g_out9: got %h expected 9", g_out); end
        load = 1'b0;
        step();
        checks++; if (g_out !== 4'h8) begin errors++; $display("FAIL os_g_out8: got %h expected 8", g_out); end
        step();
        checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL os_done_valid: got %b expected 0", g_valid); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL os_done_wrap: got %b expected 1", wrap); end
        checks++; if (g_out !== 4'h8) begin errors++; $display("FAIL os_done_g_out: got %h expected 8", g_out); end
        step();
        checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL os_stay_valid: got %b expected 0", g_valid); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL os_stay_wrap: got %b expected 0", wrap); end
        load = 1'b1; load_val = 4'h0; en = 1'b0;
        step();
        checks++; if (g_out !== 4'h0) begin errors++; $display("FAIL os_load_g_out: got %h expected 0", g_out); end
        checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL os_load_valid: got %b expected 0", g_valid); end
        load = 1'b0; en = 1'b1;
        step();
        checks++; if (g_valid !== 1'b1) begin errors++; $display("FAIL os_restart_valid: got %b expected 1", g_valid); end
        checks++; if (g_out !== 4'h0) begin errors++; $display("FAIL os_restart_g_out: got %h expected 0", g_out); end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 4'h4; en = 1'b1; dir = 1'b1; g_ready = 1'b1;
        step();
        load = 1'b0; g_ready = 1'b0;
        checks++; if (g_out !== 4'h6) begin errors++; $display("FAIL ar_pre_g_out: got %h expected 6", g_out); end
        checks++; if (g_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", g_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", g_valid); end
        checks++; if (g_out !== 4'h0) begin errors++; $display("FAIL ar_g_out: got %h expected 0", g_out); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL ar_wrap: got %b expected 0", wrap); end
        #2;
        rst_n = 1'b1; g_ready = 1'b1;
        step();
        checks++; if (g_valid !== 1'b1) begin errors++; $display("FAIL ar_restart_valid: got %b expected 1", g_valid); end
        checks++; if (g_out !== 4'h0) begin errors++; $display("FAIL ar_restart_g_out: got %h expected 0", g_out); end
        step();
        checks++; if (g_out !== 4'h1) begin errors++; $display("FAIL ar_next_g_out: got %h expected 1", g_out); end
    endtask

    initial begin
        test_reset();
`ifdef GRAY_GEN_ONESHOT_EN
        test_oneshot();
`else
        test_stream_up();
        test_backpressure();
        test_load_down();
        test_load_xfer();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
